tx_resp_arb: RTL and testbench
==============================

# tx_resp_arb

Response arbiter between the system controller's two response sources and the TX async FIFO write port, in the REF_CLK domain. It serialises ALU results (16-bit, sent as two bytes, LSB first) and register-file read data (one byte) into single-byte FIFO writes. It arbitrates round-robin when both sources request at once and throttles on FIFO full. Only whole frames are emitted; bytes from different sources never interleave.

## Interface
Parameters:
- DATA_W, 8, FIFO byte width; ALU result width is 2*DATA_W.

Ports:
- CLK  in  1  system clock (REF_CLK domain).
- RST  in  1  asynchronous reset, active-low.
- alu_req  in  1  ALU result pending; held with alu_data stable until alu_gnt.
- alu_data  in  2*DATA_W  ALU result.
- alu_gnt  out  1  one-cycle pulse: ALU result captured.
- rd_req  in  1  register read data pending; held with rd_data stable until rd_gnt.
- rd_data  in  DATA_W  register read data.
- rd_gnt  out  1  one-cycle pulse: read data captured.
- wfull  in  1  TX FIFO full (write-domain flag).
- TX_P_Data  out  DATA_W  FIFO write data.
- TX_D_VLD  out  1  FIFO write strobe (winc).
- busy  out  1  high while a frame is in progress (state != IDLE).

## Operation
- All outputs are registered. Reset values: alu_gnt=0, rd_gnt=0, TX_P_Data=0, TX_D_VLD=0, busy=0. Internal state resets to IDLE, the byte latch to 0, and the last-grant pointer to RD, so ALU wins the first tie.
- States: IDLE, ALU_LO, ALU_HI, RD_B.
- IDLE:
  - Only alu_req is high: latch alu_data, pulse alu_gnt, go to ALU_LO.
  - Only rd_req is high: latch rd_data, pulse rd_gnt, go to RD_B.
  - Both are high: grant the source opposite to the last-grant pointer.
  - Update the pointer on every grant.
- Issue rule, applied in ALU_LO, ALU_HI and RD_B: at an edge where wfull=0 and TX_D_VLD=0, set TX_D_VLD=1 with the current byte.
  - ALU_LO issues latch[DATA_W-1:0], then goes to ALU_HI.
  - ALU_HI issues latch[2*DATA_W-1:DATA_W], then goes to IDLE.
  - RD_B issues its byte, then goes to IDLE.
- Otherwise TX_D_VLD=0 and the state holds. The TX_D_VLD=0 term enforces a one-cycle gap after every write, so wfull reflects the previous write before the next issue.
- wfull=1 stalls indefinitely in the current byte state. Latched data is kept and no byte is dropped or duplicated.
- Requests arriving while busy are not granted. The requester keeps req high and is served in IDLE after the frame ends.
- TX_P_Data holds its last value when TX_D_VLD=0.
- Reset mid-frame: return to IDLE immediately (asynchronous). Any unsent byte is discarded, no partial frame is completed, and gnt pulses are cleared.

## Timing
- Edge 0 is the edge where req is sampled in IDLE.
  - gnt is high for the cycle after edge 0.
  - With wfull=0 throughout:
    - ALU frame: TX_D_VLD is high after edge 1 (LO byte) and after edge 3 (HI byte), and back in IDLE after edge 3.
    - RD frame: TX_D_VLD is high after edge 1, and back in IDLE after edge 1.
- Earliest next grant:
  - Edge 4 after an ALU grant.
  - Edge 2 after an RD grant.
- Peak throughput is one FIFO write per two cycles.
- A wfull stall of n edges delays every later event by n cycles.
- The requester must drop req at the edge after it sees gnt. The arbiter ignores req outside IDLE, so no double grant is possible.

## Test plan
- Single ALU request, alu_data=16'hA55A, wfull=0:
  - alu_gnt pulses once.
  - Writes are 8'h5A then 8'hA5, on cycles 1 and 3.
  - busy=0 from cycle 4.
- alu_req and rd_req rise together right after reset, rd_data=8'h3C, alu_data=16'h1234:
  - Writes are 8'h34, 8'h12, 8'h3C in that order.
  - A second simultaneous pair is granted RD first.
- RD request with wfull held high for 5 cycles after the grant:
  - No TX_D_VLD while wfull is high.
  - Exactly one write of rd_data on the first edge after wfull falls.
- wfull asserted between the ALU LO and HI bytes:
  - HI byte is held until wfull falls and is written exactly once.
  - No rd_gnt is issued meanwhile, even with rd_req high.
- RST pulsed low while in ALU_HI:
  - All outputs are 0 immediately and no HI byte is written.
  - The next alu_req restarts a full two-byte frame.
- Back-to-back: 4 RD requests, each held until its grant, wfull=0:
  - Four writes, each separated by exactly one idle cycle.
  - No gnt while busy.

Source files
------------

// File: rtl/tx_resp_arb.sv
// Response arbiter: serialises ALU results (two bytes, LSB first) and
// register read data (one byte) into single-byte TX FIFO writes.
module tx_resp_arb #(
    parameter int DATA_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                alu_req,
    input  logic [2*DATA_W-1:0] alu_data,
    output logic                alu_gnt,
    input  logic                rd_req,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                rd_gnt,
    input  logic                wfull,
    output logic [DATA_W-1:0]   TX_P_Data,
    output logic                TX_D_VLD,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALU_LO = 2'd1,
        ALU_HI = 2'd2,
        RD_B   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [2*DATA_W-1:0] latch_q, latch_d;
    logic                last_alu_q, last_alu_d;
    logic                alu_gnt_q, alu_gnt_d;
    logic                rd_gnt_q, rd_gnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                vld_q, vld_d;
    logic                busy_q, busy_d;

    logic grant_alu;
    logic grant_rd;
    logic issue;

    // Round-robin pick in IDLE: on a tie ALU wins unless it won last time.
    assign grant_alu = (state_q == IDLE) && alu_req &&
                       (!rd_req || !last_alu_q);
    assign grant_rd  = (state_q == IDLE) && rd_req && !grant_alu;

    // A byte may go out only with room in the FIFO and a gap after each write.
    assign issue = !wfull && !vld_q;

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            latch_q    <= '0;
            last_alu_q <= 1'b0;
            alu_gnt_q  <= 1'b0;
            rd_gnt_q   <= 1'b0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            latch_q    <= latch_d;
            last_alu_q <= last_alu_d;
            alu_gnt_q  <= alu_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
        end
    end

    // Next state: grant from IDLE, advance a byte state on each issue.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_alu) begin
                    state_d = ALU_LO;
                end else if (grant_rd) begin
                    state_d = RD_B;
                end
            end
            ALU_LO: if (issue) state_d = ALU_HI;
            ALU_HI: if (issue) state_d = IDLE;
            RD_B:   if (issue) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the latch, pointer, grants and FIFO write outputs.
    always_comb begin
        latch_d    = latch_q;
        last_alu_d = last_alu_q;
        alu_gnt_d  = grant_alu;
        rd_gnt_d   = grant_rd;
        data_d     = data_q;
        vld_d      = 1'b0;
        busy_d     = (state_d != IDLE);
        if (grant_alu) begin
            latch_d    = alu_data;
            last_alu_d = 1'b1;
        end else if (grant_rd) begin
            latch_d    = {{DATA_W{1'b0}}, rd_data};
            last_alu_d = 1'b0;
        end
        if (issue) begin
            case (state_q)
                ALU_LO, RD_B: begin
                    vld_d  = 1'b1;
                    data_d = latch_q[DATA_W-1:0];
                end
                ALU_HI: begin
                    vld_d  = 1'b1;
                    data_d = latch_q[2*DATA_W-1:DATA_W];
                end
                default: begin
                    vld_d  = 1'b0;
                    data_d = data_q;
                end
            endcase
        end
    end

    assign alu_gnt   = alu_gnt_q;
    assign rd_gnt    = rd_gnt_q;
    assign TX_P_Data = data_q;
    assign TX_D_VLD  = vld_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tx_resp_arb.sv
// Bench for tx_resp_arb: directed scenarios plus random traffic,
// checked cycle by cycle against a frame-queue reference model.
module tb_tx_resp_arb;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        alu_req = 1'b0;
    logic [15:0] alu_data = '0;
    logic        alu_gnt;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_data = '0;
    logic        rd_gnt;
    logic        wfull = 1'b0;
    logic [7:0]  TX_P_Data;
    logic        TX_D_VLD;
    logic        busy;

    tx_resp_arb #(.DATA_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .alu_req(alu_req), .alu_data(alu_data), .alu_gnt(alu_gnt),
        .rd_req(rd_req), .rd_data(rd_data), .rd_gnt(rd_gnt),
        .wfull(wfull), .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: bytes still owed for the frame in flight.
    logic [7:0] m_q[$];
    bit         m_last_alu = 0;
    bit         m_ag = 0, m_rg = 0, m_vld = 0;
    logic [7:0] m_data = '0;
    logic [7:0] wlog[$];
    int         cyc = 0;
    int         wcyc[$];

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last_alu = 0;
        m_ag = 0; m_rg = 0; m_vld = 0; m_data = '0;
    endtask

    task automatic model_edge();
        m_ag = 0; m_rg = 0;
        if (m_q.size() == 0) begin
            m_vld = 0;
            if (alu_req && (!rd_req || !m_last_alu)) begin
                m_q.push_back(alu_data[7:0]);
                m_q.push_back(alu_data[15:8]);
                m_ag = 1; m_last_alu = 1;
            end else if (rd_req) begin
                m_q.push_back(rd_data);
                m_rg = 1; m_last_alu = 0;
            end
        end else if (!wfull && !m_vld) begin
            m_data = m_q.pop_front();
            m_vld = 1;
        end else begin
            m_vld = 0;
        end
    endtask

    task automatic check_all();
        chk("alu_gnt", {15'd0, alu_gnt}, {15'd0, m_ag});
        chk("rd_gnt", {15'd0, rd_gnt}, {15'd0, m_rg});
        chk("vld", {15'd0, TX_D_VLD}, {15'd0, m_vld});
        chk("data", {8'd0, TX_P_Data}, {8'd0, m_data});
        chk("busy", {15'd0, busy}, {15'd0, (m_q.size() != 0)});
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        cyc++;
        check_all();
        if (TX_D_VLD) begin
            wlog.push_back(TX_P_Data);
            wcyc.push_back(cyc);
        end
        if (alu_gnt) alu_req = 1'b0;
        if (rd_gnt) rd_req = 1'b0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit a_drop, r_drop;
        // Reset values
        #1;
        chk("rst_gnt", {14'd0, alu_gnt, rd_gnt}, 16'd0);
        chk("rst_out", {7'd0, TX_D_VLD, TX_P_Data}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        model_reset();

        // Single ALU frame
        wlog.delete(); wcyc.delete(); cyc = 0;
        alu_data = 16'hA55A; alu_req = 1'b1;
        run(6);
        chk("alu_nw", 16'(wlog.size()), 16'd2);
        if (wlog.size() == 2) begin
            chk("alu_b0", {8'd0, wlog[0]}, 16'h005A);
            chk("alu_b1", {8'd0, wlog[1]}, 16'h00A5);
            chk("alu_c0", 16'(wcyc[0]), 16'd2);
            chk("alu_c1", 16'(wcyc[1]), 16'd4);
        end

        // Simultaneous pair after reset, ALU re-requests during its frame
        RST = 1'b0; #1; model_reset(); RST = 1'b1;
        wlog.delete();
        alu_data = 16'h1234; alu_req = 1'b1;
        rd_data = 8'h3C; rd_req = 1'b1;
        step();
        chk("tie_alu", {15'd0, alu_gnt}, 16'd1);
        alu_data = 16'h5678; alu_req = 1'b1;
        run(3);
        step();
        chk("tie2_rd", {14'd0, alu_gnt, rd_gnt}, 16'd1);
        run(8);
        chk("pair_nw", 16'(wlog.size()), 16'd5);
        if (wlog.size() == 5) begin
            chk("pair_b0", {8'd0, wlog[0]}, 16'h0034);
            chk("pair_b1", {8'd0, wlog[1]}, 16'h0012);
            chk("pair_b2", {8'd0, wlog[2]}, 16'h003C);
            chk("pair_b3", {8'd0, wlog[3]}, 16'h0078);
        end

        // RD with wfull high for 5 cycles after grant
        wlog.delete();
        rd_data = 8'hC7; rd_req = 1'b1;
        step();
        wfull = 1'b1;
        run(5);
        wfull = 1'b0;
        run(3);
        chk("stall_nw", 16'(wlog.size()), 16'd1);

        // wfull between ALU LO and HI, rd_req pending
        wlog.delete();
        alu_data = 16'hBEEF; alu_req = 1'b1;
        run(2);
        wfull = 1'b1;
        rd_data = 8'h99; rd_req = 1'b1;
        run(4);
        wfull = 1'b0;
        run(6);
        chk("mid_nw", 16'(wlog.size()), 16'd3);

        // Reset while in ALU_HI
        alu_data = 16'hCAFE; alu_req = 1'b1;
        run(2);
        RST = 1'b0;
        #1;
        model_reset();
        chk("arst_out", {5'd0, alu_gnt, rd_gnt, TX_D_VLD, TX_P_Data}, 16'd0);
        chk("arst_busy", {15'd0, busy}, 16'd0);
        @(posedge CLK); #1;
        chk("arst_hold", {7'd0, TX_D_VLD, TX_P_Data}, 16'd0);
        RST = 1'b1;
        wlog.delete();
        alu_data = 16'h0FF0; alu_req = 1'b1;
        run(6);
        chk("rst_nw", 16'(wlog.size()), 16'd2);

        // Four back-to-back RD requests
        wlog.delete(); wcyc.delete();
        for (int k = 0; k < 4; k++) begin
            rd_data = 8'(8'h10 + k); rd_req = 1'b1;
            run(2);
        end
        run(2);
        chk("b2b_nw", 16'(wlog.size()), 16'd4);
        if (wcyc.size() == 4)
            for (int k = 1; k < 4; k++)
                chk("b2b_gap", 16'(wcyc[k] - wcyc[k-1]), 16'd2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            a_drop = alu_gnt; r_drop = rd_gnt;
            if (!alu_req && !a_drop && ($urandom % 3 == 0)) begin
                alu_data = 16'($urandom); alu_req = 1'b1;
            end
            if (!rd_req && !r_drop && ($urandom % 3 == 0)) begin
                rd_data = 8'($urandom); rd_req = 1'b1;
            end
            wfull = ($urandom % 4 == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
